// File: rtl/ram_pingpong.sv
// Double-buffered two-bank RAM: a producer fills one bank while a consumer drains the other.
// Bank ownership moves through done/ready handoffs; misuse raises sticky error flags.
module ram_pingpong #(
  parameter int bw     = 32,
  parameter int aw     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          wr,
  input  logic [aw-1:0] adrr_wr,
  input  logic [bw-1:0] data_wr,
  input  logic          wr_done,
  output logic          wr_ready,
  input  logic          rd,
  input  logic [aw-1:0] adrr_rd,
  input  logic          rd_done,
  output logic          rd_ready,
  output logic [bw-1:0] data_rd,
  output logic          rd_valid,
  output logic [1:0]    fill_cnt,
  output logic          err_ovf,
  output logic          err_udf
);

  localparam int DEPTH = 2 ** (aw + 1);

  // Valid/ready semantics: an operation takes effect only in a cycle where its strobe
  // and the matching ready are both high at the rising edge; otherwise it is dropped
  // and the side's sticky error flag is set.

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;

  logic          wr_ok, rd_ok;
  logic          wr_fire, wr_done_fire;
  logic          rd_fire, rd_done_fire;

  logic [bw-1:0] mem_q [DEPTH];
  logic [bw-1:0] rd_word;

  logic          out_load;
  logic [bw-1:0] out_data;
  logic [bw-1:0] data_rd_q;
  logic          rd_valid_q;

  assign wr_ok        = !full_q[wr_bank_q];
  assign rd_ok        = full_q[rd_bank_q];
  assign wr_fire      = wr && wr_ok;
  assign wr_done_fire = wr_done && wr_ok;
  assign rd_fire      = rd && rd_ok;
  assign rd_done_fire = rd_done && rd_ok;

  // When both handoffs are legal exactly one bank is full, so they never hit the same bit.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;
    if (wr_done_fire) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (rd_done_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    if ((wr || wr_done) && !wr_ok) begin
      err_ovf_d = 1'b1;
    end
    if ((rd || rd_done) && !rd_ok) begin
      err_udf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // Storage is never reset; the bank pointer forms the address MSB.
  always_ff @(posedge Clk) begin
    if (wr_fire) begin
      mem_q[{wr_bank_q, adrr_wr}] <= data_wr;
    end
  end

  assign rd_word = mem_q[{rd_bank_q, adrr_rd}];

  // Any RD_LAT other than 2 builds the single-register path.
  if (RD_LAT == 2) begin : g_lat2
    logic [bw-1:0] s1_data_q;
    logic          s1_vld_q;

    always_ff @(posedge Clk) begin
      if (rd_fire) begin
        s1_data_q <= rd_word;
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        s1_vld_q <= 1'b0;
      end else begin
        s1_vld_q <= rd_fire;
      end
    end

    assign out_load = s1_vld_q;
    assign out_data = s1_data_q;
  end else begin : g_lat1
    assign out_load = rd_fire;
    assign out_data = rd_word;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_rd_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= out_load;
      if (out_load) begin
        data_rd_q <= out_data;
      end
    end
  end

  assign wr_ready = wr_ok;
  assign rd_ready = rd_ok;
  assign data_rd  = data_rd_q;
  assign rd_valid = rd_valid_q;
  assign fill_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;

endmodule

// File: tb/tb_ram_pingpong.sv
// Bench for ram_pingpong: one RD_LAT=1 and one RD_LAT=2 instance share the same stimulus;
// each has its own expected queue holding {due_cycle, data}.
module tb_ram_pingpong;

  logic        Clk;
  logic        Rst_n;
  logic        wr, wr_done, rd, rd_done;
  logic [7:0]  adrr_wr, adrr_rd;
  logic [31:0] data_wr;

  logic        wr_ready1, rd_ready1, rd_valid1, err_ovf1, err_udf1;
  logic [31:0] data_rd1;
  logic [1:0]  fill_cnt1;
  logic        wr_ready2, rd_ready2, rd_valid2, err_ovf2, err_udf2;
  logic [31:0] data_rd2;
  logic [1:0]  fill_cnt2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] exp_q1[$];
  logic [63:0] exp_q2[$];

  ram_pingpong #(.bw(32), .aw(8), .RD_LAT(1)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n),
    .wr(wr), .adrr_wr(adrr_wr), .data_wr(data_wr), .wr_done(wr_done), .wr_ready(wr_ready1),
    .rd(rd), .adrr_rd(adrr_rd), .rd_done(rd_done), .rd_ready(rd_ready1),
    .data_rd(data_rd1), .rd_valid(rd_valid1), .fill_cnt(fill_cnt1),
    .err_ovf(err_ovf1), .err_udf(err_udf1)
  );

  ram_pingpong #(.bw(32), .aw(8), .RD_LAT(2)) u_dut2 (
    .Clk(Clk), .Rst_n(Rst_n),
    .wr(wr), .adrr_wr(adrr_wr), .data_wr(data_wr), .wr_done(wr_done), .wr_ready(wr_ready2),
    .rd(rd), .adrr_rd(adrr_rd), .rd_done(rd_done), .rd_ready(rd_ready2),
    .data_rd(data_rd2), .rd_valid(rd_valid2), .fill_cnt(fill_cnt2),
    .err_ovf(err_ovf2), .err_udf(err_udf2)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    wr      = 1'b0;
    wr_done = 1'b0;
    rd      = 1'b0;
    rd_done = 1'b0;
  endtask

  // Called while driving a read that must be accepted; due cycle = now + latency.
  task automatic push_rd(input logic [31:0] d, input bit to1, input bit to2);
    logic [31:0] c1, c2;
    c1 = 32'(cyc + 1);
    c2 = 32'(cyc + 2);
    if (to1) exp_q1.push_back({c1, d});
    if (to2) exp_q2.push_back({c2, d});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_ready1"}, 64'(wr_ready1), 64'd1);
    check({tag, "_rd_ready1"}, 64'(rd_ready1), 64'd0);
    check({tag, "_rd_valid1"}, 64'(rd_valid1), 64'd0);
    check({tag, "_data_rd1"},  64'(data_rd1),  64'd0);
    check({tag, "_fill1"},     64'(fill_cnt1), 64'd0);
    check({tag, "_ovf1"},      64'(err_ovf1),  64'd0);
    check({tag, "_udf1"},      64'(err_udf1),  64'd0);
    check({tag, "_wr_ready2"}, 64'(wr_ready2), 64'd1);
    check({tag, "_rd_ready2"}, 64'(rd_ready2), 64'd0);
    check({tag, "_rd_valid2"}, 64'(rd_valid2), 64'd0);
    check({tag, "_data_rd2"},  64'(data_rd2),  64'd0);
    check({tag, "_fill2"},     64'(fill_cnt2), 64'd0);
    check({tag, "_ovf2"},      64'(err_ovf2),  64'd0);
    check({tag, "_udf2"},      64'(err_udf2),  64'd0);
  endtask

  task automatic check_state(input string tag, input logic [1:0] fill, input logic wrr,
                             input logic rdr);
    check({tag, "_fill1"},     64'(fill_cnt1), 64'(fill));
    check({tag, "_wr_ready1"}, 64'(wr_ready1), 64'(wrr));
    check({tag, "_rd_ready1"}, 64'(rd_ready1), 64'(rdr));
    check({tag, "_fill2"},     64'(fill_cnt2), 64'(fill));
    check({tag, "_wr_ready2"}, 64'(wr_ready2), 64'(wrr));
    check({tag, "_rd_ready2"}, 64'(rd_ready2), 64'(rdr));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    logic [63:0] e;
    if (Rst_n) begin
      if (rd_valid1) begin
        if (exp_q1.size() == 0) begin
          check("rd1_unexpected_valid", 64'(rd_valid1), 64'd0);
        end else begin
          e = exp_q1.pop_front();
          check("rd1_cycle", 64'(cyc), 64'(e[63:32]));
          check("rd1_data", 64'(data_rd1), 64'(e[31:0]));
        end
      end
      if (rd_valid2) begin
        if (exp_q2.size() == 0) begin
          check("rd2_unexpected_valid", 64'(rd_valid2), 64'd0);
        end else begin
          e = exp_q2.pop_front();
          check("rd2_cycle", 64'(cyc), 64'(e[63:32]));
          check("rd2_data", 64'(data_rd2), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    Rst_n   = 1'b0;
    idle();
    adrr_wr = '0;
    adrr_rd = '0;
    data_wr = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset("reset");
    tick();
    Rst_n = 1'b1;

    // Fill bank 0 with i+100, then close it.
    for (int i = 0; i < 256; i++) begin
      wr = 1'b1; adrr_wr = 8'(i); data_wr = 32'(i + 100);
      tick();
    end
    wr = 1'b0; wr_done = 1'b1;
    tick();
    idle();
    @(negedge Clk);
    check_state("bank0_full", 2'd1, 1'b1, 1'b1);
    tick();

    // Ping-pong: drain bank 0 back-to-back while filling bank 1; last cycle closes both.
    for (int i = 0; i < 256; i++) begin
      rd = 1'b1; adrr_rd = 8'(i); push_rd(32'(i + 100), 1'b1, 1'b1);
      wr = 1'b1; adrr_wr = 8'(i); data_wr = 32'(32'hA0 + i);
      if (i == 255) begin
        rd_done = 1'b1;
        wr_done = 1'b1;
      end
      tick();
    end
    idle();
    @(negedge Clk);
    check_state("swap", 2'd1, 1'b1, 1'b1);
    tick();
    rd = 1'b1; adrr_rd = 8'd5; push_rd(32'hA5, 1'b1, 1'b1);
    tick();
    idle();

    // Overflow: fill bank 0 too, then misuse the write side.
    wr = 1'b1; adrr_wr = 8'd0; data_wr = 32'h1234;
    tick();
    adrr_wr = 8'd7; data_wr = 32'h77;
    tick();
    wr = 1'b0; wr_done = 1'b1;
    tick();
    idle();
    @(negedge Clk);
    check_state("both_full", 2'd2, 1'b0, 1'b1);
    check("ovf1_before", 64'(err_ovf1), 64'd0);
    tick();
    wr = 1'b1; adrr_wr = 8'd0; data_wr = 32'hDEAD; wr_done = 1'b1;
    tick();
    idle();
    @(negedge Clk);
    check("ovf1_set", 64'(err_ovf1), 64'd1);
    check("ovf2_set", 64'(err_ovf2), 64'd1);
    check_state("ovf_ignored", 2'd2, 1'b0, 1'b1);
    tick();

    // Reset while a read is still in the RD_LAT=2 pipeline.
    rd = 1'b1; adrr_rd = 8'd9; push_rd(32'hA9, 1'b1, 1'b0);
    tick();
    idle();
    @(negedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    repeat (4) tick();

    // Underflow right after reset.
    rd = 1'b1; adrr_rd = 8'd0;
    tick();
    idle();
    @(negedge Clk);
    check("udf1_set", 64'(err_udf1), 64'd1);
    check("udf2_set", 64'(err_udf2), 64'd1);
    check("udf_rd_valid1", 64'(rd_valid1), 64'd0);
    tick();
    rd_done = 1'b1;
    tick();
    idle();

    // rd_bank must still be 0: close bank 0 and expect it readable.
    wr = 1'b1; adrr_wr = 8'd3; data_wr = 32'h333;
    tick();
    wr = 1'b0; wr_done = 1'b1;
    tick();
    idle();
    @(negedge Clk);
    check_state("post_udf", 2'd1, 1'b1, 1'b1);
    check("ovf1_after_rst", 64'(err_ovf1), 64'd0);
    tick();
    rd = 1'b1; adrr_rd = 8'd0; push_rd(32'h1234, 1'b1, 1'b1);
    tick();
    adrr_rd = 8'd3; rd_done = 1'b1; push_rd(32'h333, 1'b1, 1'b1);
    tick();
    idle();
    @(negedge Clk);
    check_state("released", 2'd0, 1'b1, 1'b0);
    tick();

    // Write and close bank 1 in one cycle; untouched words survive the reset.
    wr = 1'b1; adrr_wr = 8'd0; data_wr = 32'h555; wr_done = 1'b1;
    tick();
    idle();
    rd = 1'b1; adrr_rd = 8'd0; push_rd(32'h555, 1'b1, 1'b1);
    tick();
    adrr_rd = 8'd5; push_rd(32'hA5, 1'b1, 1'b1);
    tick();
    idle();
    repeat (4) tick();

    @(negedge Clk);
    check("q1_drained", 64'(exp_q1.size()), 64'd0);
    check("q2_drained", 64'(exp_q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
